reg_pair_ctrl: RTL

Sequencer that services 16-bit register-pair requests (read, load, increment, decrement of BC/DE/HL) by driving the 8-bit, single-write-port interface of `reg_file`. It sits between the CPU control/datapath and `reg_file`. It owns the read-select and write-port signals during a pair operation and splits each pair access into byte-wide reads and writes over several cycles.

---
 rtl/gb_reg_pkg.sv | 14 +
 rtl/reg_pair_decode.sv | 16 +
 rtl/reg_pair_ctrl.sv | 75 +++++++
 3 files changed

// File: rtl/gb_reg_pkg.sv
// gb_reg_pkg: register indices, pair/op codes and sequencer states shared by register-pair logic
package gb_reg_pkg;
  localparam logic [2:0] REG_B      = 3'd0;
  localparam logic [2:0] REG_C      = 3'd1;
  localparam logic [2:0] REG_D      = 3'd2;
  localparam logic [2:0] REG_E      = 3'd3;
  localparam logic [2:0] REG_H      = 3'd4;
  localparam logic [2:0] REG_L      = 3'd5;
  localparam logic [2:0] REG_HL_IND = 3'd6;
  localparam logic [2:0] REG_A      = 3'd7;
  typedef enum logic [1:0] {OP_READ, OP_LOAD, OP_INC, OP_DEC} op_e;
  typedef enum logic [1:0] {PAIR_BC, PAIR_DE, PAIR_HL, PAIR_ILL} pair_e;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_HI, S_WR_LO, S_DONE} state_e;
endpackage

// File: rtl/reg_pair_decode.sv
// reg_pair_decode: maps a 2-bit pair code to its hi/lo register selects and an illegal flag
module reg_pair_decode
  import gb_reg_pkg::*;
(
  input  logic [1:0] pair,
  output logic [2:0] hi_sel,
  output logic [2:0] lo_sel,
  output logic       illegal
);
  // illegal pair yields zero selects so nothing downstream can address (HL) or A
  always_comb begin
    illegal = pair == PAIR_ILL;
    hi_sel  = pair == PAIR_BC ? REG_B : pair == PAIR_DE ? REG_D : pair == PAIR_HL ? REG_H : 3'd0;
    lo_sel  = pair == PAIR_BC ? REG_C : pair == PAIR_DE ? REG_E : pair == PAIR_HL ? REG_L : 3'd0;
  end
endmodule

// File: rtl/reg_pair_ctrl.sv
// reg_pair_ctrl: sequences 16-bit pair read/load/inc/dec over the byte-wide reg_file port
module reg_pair_ctrl
  import gb_reg_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_pair,
  input  logic [15:0] req_data,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_err,
  output logic [2:0]  rf_out1_sel,
  output logic [2:0]  rf_out2_sel,
  input  logic [7:0]  rf_out1,
  input  logic [7:0]  rf_out2,
  output logic [7:0]  rf_data_in,
  output logic [2:0]  rf_data_in_sel,
  output logic        rf_write_reg
);
  state_e      state, state_n;
  op_e         op_q;
  logic [2:0]  hi_q, lo_q, hi_d, lo_d;
  logic        err_q, ill_d, accept;
  logic [15:0] val_q, rd;
  reg_pair_decode u_dec (.pair(req_pair), .hi_sel(hi_d), .lo_sel(lo_d), .illegal(ill_d));
  assign req_ready = state == S_IDLE && !reset;
  assign accept    = req_valid && req_ready;
  assign rd        = {rf_out1, rf_out2};
  // next-state: illegal pairs skip straight to DONE, LOAD skips the read
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = !accept ? S_IDLE : ill_d ? S_DONE : req_op == OP_LOAD ? S_WR_HI : S_RD;
      S_RD:    state_n = op_q == OP_READ ? S_DONE : S_WR_HI;
      S_WR_HI: state_n = S_WR_LO;
      S_WR_LO: state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  // state register plus request latch; the RD cycle folds the +/-1 into the held value
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      op_q  <= OP_READ;
      hi_q  <= 3'd0;
      lo_q  <= 3'd0;
      err_q <= 1'b0;
      val_q <= 16'd0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q  <= op_e'(req_op);
        hi_q  <= hi_d;
        lo_q  <= lo_d;
        err_q <= ill_d;
        val_q <= req_data;
      end else if (state == S_RD)
        val_q <= op_q == OP_READ ? rd : op_q == OP_INC ? rd + 16'd1 : rd - 16'd1;
    end
  end
  // outputs decoded from registered state; the write strobe is cut during reset so an abort never lands a byte
  always_comb begin
    resp_valid     = state == S_DONE;
    resp_err       = resp_valid && err_q;
    resp_data      = resp_valid && !err_q ? val_q : 16'd0;
    rf_out1_sel    = state == S_RD ? hi_q : 3'd0;
    rf_out2_sel    = state == S_RD ? lo_q : 3'd0;
    rf_write_reg   = (state == S_WR_HI || state == S_WR_LO) && !reset;
    rf_data_in_sel = state == S_WR_HI ? hi_q : state == S_WR_LO ? lo_q : 3'd0;
    rf_data_in     = state == S_WR_HI ? val_q[15:8] : state == S_WR_LO ? val_q[7:0] : 8'd0;
  end
endmodule
